// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings shared by the multiply/divide unit and its decoders
package muldiv_pkg;
  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_t;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the execute stage and the multiply/divide unit
interface muldiv_if #(parameter int WIDTH = 32);
  logic               start_i;
  logic [1:0]         op_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               annul_i;
  logic               stall_o;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] result_o;
  modport master(output start_i, op_i, a_i, b_i, annul_i, input stall_o, busy_o, done_o, result_o);
  modport slave(input start_i, op_i, a_i, b_i, annul_i, output stall_o, busy_o, done_o, result_o);
endinterface

// File: rtl/md_negate.sv
// md_negate: conditional two's-complement negation, y = neg ? -x : x
module md_negate #(parameter int W = 32) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative one-bit-per-cycle signed/unsigned multiply and divide with {hi,lo} result
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  state_t             state;
  op_t                opReg;
  logic [CNT_W-1:0]   cnt;
  logic               signA, signB;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc, result;
  op_t                opIn;
  logic               accept, inSigned, inDiv, inSignA, inSignB, regDiv;
  logic [WIDTH-1:0]   absA, absB, quoFix, remFix;
  logic [2*WIDTH-1:0] prodFix, mulNext, divNext;
  logic [WIDTH:0]     mulSum, divRem, divDiff;
  assign opIn     = op_t'(bus.op_i);
  assign inSigned = (opIn == OP_MULT) || (opIn == OP_DIV);
  assign inDiv    = (opIn == OP_DIV) || (opIn == OP_DIVU);
  assign inSignA  = inSigned & bus.a_i[WIDTH-1];
  assign inSignB  = inSigned & bus.b_i[WIDTH-1];
  assign regDiv   = (opReg == OP_DIV) || (opReg == OP_DIVU);
  assign accept   = (state == IDLE) & bus.start_i & ~bus.annul_i;
  md_negate #(.W(WIDTH)) uAbsA (.x(bus.a_i), .neg(inSignA), .y(absA));
  md_negate #(.W(WIDTH)) uAbsB (.x(bus.b_i), .neg(inSignB), .y(absB));
  // Multiply: acc = {partial hi, remaining multiplier bits}, shifted right each step
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mulNext = {mulSum, acc[WIDTH-1:1]};
  // Divide: acc = {remainder, dividend/quotient}, shifted left with a restoring trial subtract
  assign divRem  = acc[2*WIDTH-1:WIDTH-1];
  assign divDiff = divRem - {1'b0, opnd};
  assign divNext = divDiff[WIDTH] ? {divRem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  md_negate #(.W(2*WIDTH)) uFixProd (.x(acc), .neg(signA ^ signB), .y(prodFix));
  md_negate #(.W(WIDTH)) uFixQuo (.x(acc[WIDTH-1:0]), .neg(signA ^ signB), .y(quoFix));
  md_negate #(.W(WIDTH)) uFixRem (.x(acc[2*WIDTH-1:WIDTH]), .neg(signA), .y(remFix));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      opReg  <= OP_MULT;
      cnt    <= '0;
      signA  <= 1'b0;
      signB  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      result <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        opReg <= opIn;
        signA <= inSignA;
        signB <= inSignB;
        cnt   <= '0;
        opnd  <= inDiv ? absB : absA;
        acc   <= {{WIDTH{1'b0}}, inDiv ? absA : absB};
        if (inDiv && bus.b_i == '0) begin
          result <= {bus.a_i, {WIDTH{1'b1}}};
          state  <= DONE;
        end else begin
          state <= BUSY;
        end
      end
    end else if (bus.annul_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        BUSY: begin
          acc <= regDiv ? divNext : mulNext;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIXUP;
        end
        FIXUP: begin
          result <= regDiv ? {remFix, quoFix} : prodFix;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.stall_o  = accept | (state == BUSY) | (state == FIXUP);
  assign bus.busy_o   = state != IDLE;
  assign bus.done_o   = (state == DONE) & ~bus.annul_i;
  assign bus.result_o = result;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the execute stage. Computes signed and unsigned multiply and divide at one bit per cycle. Returns a {hi,lo} pair for the HI/LO register path and raises a combinational stall to hold the pipeline while it runs. Supports annulment from pipeline flush.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start_i  in  1  request; sampled only in IDLE
op_i  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
a_i  in  WIDTH  multiplicand / dividend
b_i  in  WIDTH  multiplier / divisor
annul_i  in  1  abort current operation (flush)
stall_o  out  1  hold E stage (combinational)
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle result-valid pulse
result_o  out  2*WIDTH  {hi,lo}; registered, held until next completion

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, result_o 0, done_o 0, busy_o 0, internal accumulators 0. Reset mid-operation discards the operation; no done_o.
- States: IDLE, BUSY, FIXUP, DONE.
- IDLE: if start_i & ~annul_i in cycle T, latch |a|, |b|, sign flags (signed ops only), clear counter.
  - Divide with b_i==0: go to DONE at T+1.
  - Otherwise go to BUSY at T+1.
- BUSY: one iteration per cycle, WIDTH cycles (T+1..T+WIDTH), then FIXUP.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes.
- FIXUP (T+WIDTH+1): apply sign correction.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Write result_o.
- DONE (T+WIDTH+2, or T+1 for divide-by-zero): done_o=1, state goes to IDLE at the next edge. start_i is not sampled in DONE.
- Result layout:
  - MULT/MULTU: result_o = full 2*WIDTH product.
  - DIV/DIVU: hi = remainder, lo = quotient.
- Divide by zero: lo = all ones, hi = a_i unmodified (both signed and unsigned).
- Signed overflow MIN / -1: lo = MIN, hi = 0. This falls out of the magnitude algorithm and needs no special case.
- stall_o = (IDLE & start_i & ~annul_i) | BUSY | FIXUP. stall_o=0 in DONE, so the E stage advances on the DONE edge and start_i reflects the next instruction afterwards.
- busy_o = 1 in BUSY, FIXUP and DONE.
- annul_i:
  - In BUSY, FIXUP or DONE: state goes to IDLE at the next edge, done_o is suppressed (0 in that cycle even if in DONE), result_o keeps its old value.
  - annul_i and start_i together in IDLE: the start is ignored.
- result_o changes only on the FIXUP edge, or the divide-by-zero entry edge. It is stable at all other times.
- All arithmetic is unsigned on magnitudes. Negation is two's complement at 2*WIDTH (product) or WIDTH (quotient/remainder).

Decomposition:
- Shared package muldiv_pkg holds the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state encodings. The ALU-control decoder imports the op encodings from it.
- One sub-module, md_negate (parametrised width; conditional two's-complement: y = neg ? -x : x). It is instantiated for operand magnitude and for result fixup.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=7, start at T -> stall_o high T..T+33; done_o at T+34; result_o=0xFFFFFFFF_FFFFFFEB.
2. MULTU a=b=0xFFFFFFFF -> result_o=0xFFFFFFFE_00000001 at T+34. Then DIV a=0xFFFFFFF9 (-7), b=2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD}. DIVU 100/7 -> {0x2, 0xE}.
3. DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. DIVU 0x64 / 0 -> done_o at T+1 with {0x00000064, 0xFFFFFFFF}, stall_o high only in cycle T.
4. Start MULT, assert annul_i at T+10 -> IDLE at T+11, busy_o=0, no done_o, result_o retains previous value. A new DIVU 9/3 at T+12 completes at T+46 with {0, 3}.
5. Assert rst asynchronously mid-BUSY -> all outputs 0 immediately, no done_o. After release, MULT 6*7 returns 0x2A.
6. Hold start_i high across the DONE cycle (new instruction behind it) -> the second op is accepted only from IDLE after DONE, with no duplicate done_o. start_i with annul_i together in IDLE -> no acceptance, stall_o=0.
